uart_tx_fifo: RTL and testbench

- CPU-side UART transmit path: a byte FIFO written by the core via UARTOp, plus an 8N1 serializer that drains the FIFO onto the tx line.
- Mirrors the receive-side FIFO.
- Sits between the datapath's UART store path (data_in, UARTOp) and the board TX pin.
- Status outputs feed the UART status read path.

---
 rtl/uart_tx_fifo.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: CPU-side UART transmit path. The core pushes bytes with
// UARTOp == 2'b10 into a DEPTH x 8 circular FIFO. An 8N1 serializer drains
// the FIFO onto the tx pin, LSB first.
//
// Optional build macro: UART_TX_PARITY_EN. When it is defined, an even-parity
// bit is sent between the last data bit and the stop bit, giving an 11-bit frame.
//
// Ports:
//   clk      system clock
//   reset    synchronous, active-high; aborts any frame in flight and empties the FIFO
//   UARTOp   2'b10 pushes data_in[7:0]; every other code is ignored here
//   data_in  store data from the core; only [7:0] is used
//   tx       registered serial line, idles high
//   busy     serializer is not in IDLE
//   full     count == DEPTH
//   empty    count == 0
//   count    FIFO occupancy
module uart_tx_fifo #(
   parameter int DEPTH        = 16,
   parameter int CLKS_PER_BIT = 868
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [1:0]             UARTOp,
   input  logic [31:0]            data_in,
   output logic                   tx,
   output logic                   busy,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] PARITY = 3'd3;
`endif

   logic [7:0]    r_buf [DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_count;
   logic [2:0]    r_state;
   logic          r_tx;
   logic [BW-1:0] r_baud;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
`ifdef UART_TX_PARITY_EN
   logic          r_par;
`endif

   logic w_push, w_pop, w_bit_end;

   assign w_bit_end = (r_baud == BAUD_LAST);
   // full is sampled before the pop of the same edge, so a push that meets
   // a pop while full is dropped.
   assign w_push    = (UARTOp == 2'b10) && !full;
   // Pops only come from IDLE or the last cycle of STOP. A byte pushed into an
   // empty FIFO is not popped on the same edge, because r_count is still zero.
   assign w_pop     = (r_count != '0) &&
                      ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));

   // Storage has no reset. Stale entries can never be read, because the
   // occupancy count guards every pop.
   always_ff @(posedge clk) begin
      if (w_push) r_buf[r_wr_ptr] <= data_in[7:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_tx    <= 1'b1;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
`ifdef UART_TX_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               r_tx <= 1'b1;
               if (w_pop) begin
                  r_shift <= r_buf[r_rd_ptr];
`ifdef UART_TX_PARITY_EN
                  r_par   <= ^r_buf[r_rd_ptr];
`endif
                  r_tx    <= 1'b0;
                  r_baud  <= '0;
                  r_state <= START;
               end
            end
            START: begin
               if (w_bit_end) begin
                  r_tx    <= r_shift[0];
                  r_bit   <= '0;
                  r_baud  <= '0;
                  r_state <= DATA;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            DATA: begin
               if (w_bit_end) begin
                  r_baud <= '0;
                  if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     r_tx    <= r_par;
                     r_state <= PARITY;
`else
                     r_tx    <= 1'b1;
                     r_state <= STOP;
`endif
                  end else begin
                     // Next bit out is shift[1], which becomes shift[0] after the shift.
                     r_shift <= {1'b0, r_shift[7:1]};
                     r_tx    <= r_shift[1];
                     r_bit   <= r_bit + 3'd1;
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (w_bit_end) begin
                  r_baud  <= '0;
                  r_tx    <= 1'b1;
                  r_state <= STOP;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
`endif
            STOP: begin
               if (w_bit_end) begin
                  r_baud <= '0;
                  if (w_pop) begin
                     // Start the next frame immediately, with no idle gap.
                     r_shift <= r_buf[r_rd_ptr];
`ifdef UART_TX_PARITY_EN
                     r_par   <= ^r_buf[r_rd_ptr];
`endif
                     r_tx    <= 1'b0;
                     r_state <= START;
                  end else begin
                     r_state <= IDLE;
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end

   assign tx    = r_tx;
   assign busy  = (r_state != IDLE);
   assign full  = (r_count == DEPTH_C);
   assign empty = (r_count == '0);
   assign count = r_count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo at CLKS_PER_BIT=4, DEPTH=16.
// A queue-based reference model predicts occupancy, drops, pop times and the tx
// waveform. Accepted bytes go into an expected-frame queue. A line monitor
// captures each frame from its start bit and checks it against that queue.
module tb_uart_tx_fifo;
   localparam int DEPTH = 16;
   localparam int CPB   = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   localparam int FCYC = FB * CPB;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  UARTOp = 2'b00;
   logic [31:0] data_in = '0;
   logic        tx, busy, full, empty;
   logic [$clog2(DEPTH):0] count;

   int checks = 0;
   int errors = 0;

   uart_tx_fifo #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .reset(reset), .UARTOp(UARTOp), .data_in(data_in),
      .tx(tx), .busy(busy), .full(full), .empty(empty), .count(count)
   );

   always #5 clk = ~clk;

   // Line level of bit slot i of a frame carrying byte b.
   function automatic logic frame_bit(input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      if (i <= 8) return b[i-1];
      if (i == 9 && FB == 11) return ^b;
      return 1'b1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] m_fifo[$];
   logic [7:0] exp_q[$];
   longint     t = 0;
   longint     pop_at = 0;
   bit         have_pop = 0;
   logic [7:0] cur = '0;
   bit         m_ready = 0;
   int         abort_n = 0;
   int         m_cnt = 0;
   bit         m_busy = 0;
   logic       m_tx = 1'b1;

   always @(posedge clk) begin : model
      bit was_full;
      if (reset) begin
         m_fifo.delete();
         exp_q.delete();
         have_pop = 0;
         abort_n++;
         m_ready = 1;
      end else begin
         was_full = (m_fifo.size() == DEPTH);
         if (m_fifo.size() != 0 && (!have_pop || (t - pop_at) >= FCYC)) begin
            cur = m_fifo.pop_front();
            pop_at = t;
            have_pop = 1;
         end
         if (UARTOp == 2'b10 && !was_full) begin
            m_fifo.push_back(data_in[7:0]);
            exp_q.push_back(data_in[7:0]);
         end
      end
      m_cnt  = m_fifo.size();
      m_busy = have_pop && ((t - pop_at) < FCYC);
      m_tx   = m_busy ? frame_bit(cur, int'((t - pop_at) / CPB)) : 1'b1;
      t++;
   end

   // ---------------- status checker ----------------
   always @(negedge clk) begin
      if (m_ready) begin
         chk("count", 32'(count), 32'(m_cnt));
         chk("busy",  32'(busy),  32'(m_busy));
         chk("full",  32'(full),  32'(m_cnt == DEPTH));
         chk("empty", 32'(empty), 32'(m_cnt == 0));
         chk("tx",    32'(tx),    32'(m_tx));
      end
   end

   // ---------------- line monitor ----------------
   bit   in_frame = 0;
   int   k = 0;
   int   abort_seen = 0;
   logic samp [FCYC];

   always @(negedge clk) begin : mon
      logic [7:0] e, got;
      bit ok;
      if (abort_seen != abort_n) begin
         abort_seen = abort_n;
         in_frame = 0;
      end else if (m_ready) begin
         if (!in_frame && tx === 1'b0) begin
            in_frame = 1;
            k = 0;
         end
         if (in_frame) begin
            samp[k] = tx;
            k++;
            if (k == FCYC) begin
               in_frame = 0;
               got = '0;
               for (int i = 0; i < 8; i++) got[i] = samp[(1+i)*CPB + CPB/2];
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL frame: got byte %02h, expected no frame", got);
               end else begin
                  e = exp_q.pop_front();
                  ok = 1;
                  for (int j = 0; j < FCYC; j++)
                     if (samp[j] !== frame_bit(e, j / CPB)) ok = 0;
                  if (!ok) begin
                     errors++;
                     $display("FAIL frame: got byte %02h, expected %02h", got, e);
                  end
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input logic [1:0] op, input logic [7:0] d);
      UARTOp  = op;
      data_in = {24'($urandom), d};
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      step(2'b10, d);
   endtask

   task automatic idle(input int n);
      logic [1:0] op;
      for (int i = 0; i < n; i++) begin
         case ($urandom_range(0, 2))
            0:       op = 2'b00;
            1:       op = 2'b01;
            default: op = 2'b11;
         endcase
         step(op, 8'($urandom));
      end
   endtask

   task automatic drain(input int limit);
      int n;
      n = 0;
      while ((m_busy || m_cnt != 0 || in_frame) && n < limit) begin
         idle(1);
         n++;
      end
      checks++;
      if (n >= limit) begin
         errors++;
         $display("FAIL drain: still busy after %0d cycles, expected idle", n);
      end
   endtask

   initial begin
      reset = 1'b1;
      idle(2);
      reset = 1'b0;

      // single frame
      push(8'hA5);
      idle(45);

      // back-to-back frames
      push(8'h00);
      push(8'hFF);
      idle(85);

      // overfill: the last push is dropped
      for (int i = 1; i <= 18; i++) push(8'(i));
      drain(1000);

      // reset in the middle of data bit 3
      push(8'h3C);
      idle(18);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      idle(50);
      push(8'h55);
      drain(100);

      // hold full across a STOP-end pop with a push on the same edge
      for (int i = 0; i < 42; i++) push(8'(8'h80 + i));
      drain(1000);

      // random traffic with one reset in the middle
      for (int i = 0; i < 400; i++) begin
         if (i == 200) begin
            reset = 1'b1;
            idle(1);
            reset = 1'b0;
         end else if ($urandom_range(0, 5) == 0) begin
            push(8'($urandom));
         end else begin
            idle(1);
         end
      end
      drain(2000);

      chk("leftover_frames", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
